// File: rtl/parallel_in_parallel_out_pipo_32_bit.sv
// Parallel-in/parallel-out register with a fixed latency of DEPTH cycles.
// Async active-low reset loads RESET_VALUE into every stage.
module parallel_in_parallel_out_pipo_32_bit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 1,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  output logic [WIDTH-1:0] Parallel_Data_Out
);

  generate
    if (DEPTH < 1 || DEPTH > 16 || WIDTH < 1) begin : g_bad_param
      $fatal(1, "pipo: DEPTH must be 1..16 and WIDTH >= 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= RST_V;
      end
    end else begin
      stage_q[0] <= Parallel_Data_In;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  // Output comes straight from the last flop; no input-to-output path.
  assign Parallel_Data_Out = stage_q[DEPTH-1];

endmodule

// File: tb/tb_parallel_in_parallel_out_pipo_32_bit.sv
// Bench: DEPTH=1 and DEPTH=3 instances vs a history-queue model.
// Random and directed words, mid-cycle reset, constant hold.
module tb_parallel_in_parallel_out_pipo_32_bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic [31:0] dout1;
  logic [31:0] dout3;

  int n_vec;
  int n_err;

  logic [31:0] hist[$];

  parallel_in_parallel_out_pipo_32_bit #(
    .WIDTH(32), .DEPTH(1), .RESET_VALUE(32'h0)
  ) u_d1 (
    .Clk_In(clk),
    .Reset_In(rst_n),
    .Parallel_Data_In(din),
    .Parallel_Data_Out(dout1)
  );

  parallel_in_parallel_out_pipo_32_bit #(
    .WIDTH(32), .DEPTH(3), .RESET_VALUE(32'h0)
  ) u_d3 (
    .Clk_In(clk),
    .Reset_In(rst_n),
    .Parallel_Data_In(din),
    .Parallel_Data_Out(dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output after an edge is the word captured D edges ago, else reset value.
  function automatic logic [31:0] model(input int d);
    if (hist.size() < d) return 32'h0;
    return hist[hist.size() - d];
  endfunction

  task automatic check_both(input string tag);
    chk({tag, "_d1"}, dout1, model(1));
    chk({tag, "_d3"}, dout3, model(3));
  endtask

  task automatic step(input logic [31:0] d, input string tag);
    din = d;
    @(posedge clk);
    if (rst_n) hist.push_back(d);
    #1;
    check_both(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    hist.delete();
    check_both("rst_now");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    din   = 32'hDEAD_BEEF;

    // Reset held across edges with junk on the input
    repeat (2) begin
      @(posedge clk);
      #1;
      check_both("rst_hold");
    end
    rst_n = 1'b1;

    // Directed words, one per edge
    step(32'h1234_5678, "dir0");
    step(32'hFFFF_FFFF, "dir1");
    step(32'h0000_0000, "dir2");
    step(32'hA5A5_A5A5, "dir3");

    // Random words
    for (int i = 0; i < 10; i++) begin
      step($urandom, "rand");
    end

    // Mid-cycle reset flushes everything
    step(32'hCAFE_F00D, "cafe");
    do_reset();
    step(32'h0000_0001, "post_rst");
    chk("post_rst_val", dout1, 32'h0000_0001);

    // DEPTH=3 latency from a clean start
    do_reset();
    step(32'h0000_0011, "lat1");
    chk("lat1_d3", dout3, 32'h0);
    step(32'h0000_0022, "lat2");
    chk("lat2_d3", dout3, 32'h0);
    step(32'h0000_0033, "lat3");
    chk("lat3_d3", dout3, 32'h0000_0011);
    step(32'h0000_0044, "lat4");
    chk("lat4_d3", dout3, 32'h0000_0022);
    step(32'h0000_0055, "lat5");
    chk("lat5_d3", dout3, 32'h0000_0033);

    // Constant input, MSB/LSB mapping, mid-cycle glitch check
    for (int i = 0; i < 5; i++) begin
      step(32'h8000_0001, "hold");
      #3;
      chk("hold_mid_d1", dout1, 32'h8000_0001);
    end

    // More random traffic with a reset in between
    for (int i = 0; i < 20; i++) begin
      step($urandom, "rand2");
      if (i == 9) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parallel_in_parallel_out_pipo_32_bit.md
Name: parallel_in_parallel_out_pipo_32_bit

Overview:
- 32-bit parallel-in/parallel-out register: captures the full input word on each rising clock edge and presents it on the output.
- Used as a datapath pipeline or retiming register between blocks in the same clock domain.
- Optional extra register stages (DEPTH) give a fixed, deeper latency without changing the port list.

Parameters:
- WIDTH, 32, data width in bits of input and output.
- DEPTH, 1, number of cascaded register stages; legal range 1..16; latency equals DEPTH clock cycles.
- RESET_VALUE, 32'h0000_0000, value loaded into every stage on reset, truncated to WIDTH bits.

Ports:
- Clk_In  input  1  single clock; all state updates on the rising edge.
- Reset_In  input  1  asynchronous, active-low reset: 0 = reset asserted, 1 = normal operation.
- Parallel_Data_In  input  WIDTH  data word, sampled every rising edge while out of reset.
- Parallel_Data_Out  output  WIDTH  registered data word, driven directly from the last stage flops with no combinational path from any input.

Behaviour:
- Reset
  - Reset_In low forces every stage, and therefore Parallel_Data_Out, to RESET_VALUE (default 0) immediately, independent of Clk_In.
  - Stages hold RESET_VALUE while Reset_In stays low.
  - Reset assertion mid-operation discards all in-flight words; no partial or stale data survives.
  - Reset release (0->1) is synchronous in effect: the first capture occurs on the first rising edge with Reset_In high.
  - Integrators must deassert reset away from the clock edge.
- Normal operation (Reset_In high)
  - Each rising edge: stage[0] <= Parallel_Data_In; stage[k] <= stage[k-1] for k = 1..DEPTH-1.
  - Parallel_Data_Out = stage[DEPTH-1].
- Latency and throughput
  - A word applied before edge N appears on Parallel_Data_Out after edge N+DEPTH-1.
  - With DEPTH=1, the output updates on the same edge that samples the input.
  - Throughput is one word per clock.
- No enable, no handshake: a new word is accepted every cycle unconditionally, and a constant input gives a constant output.
- Bit ordering is preserved: bit i in maps to bit i out; no shifting, inversion or reordering.
- X or unknown input bits propagate as-is and are not masked.
- Parameter checks
  - DEPTH < 1 or WIDTH < 1 is a fatal elaboration error.
  - RESET_VALUE wider than WIDTH is truncated from the MSB.

Test Plan:
1. Hold Reset_In=0 for 10 ns while Parallel_Data_In=32'hDEAD_BEEF and the clock toggles -> Parallel_Data_Out stays 32'h0000_0000.
2. Release reset, then drive 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_A5A5 on successive edges (DEPTH=1) -> each value appears on Parallel_Data_Out right after the edge that samples it, exactly one cycle per value.
3. Ten consecutive random 32-bit words at 10 ns clock period -> output matches a reference model delayed by DEPTH cycles, all bits, every cycle.
4. Output at 32'hCAFE_F00D, then pull Reset_In low between clock edges -> output becomes 32'h0000_0000 before the next rising edge; release and load 32'h0000_0001 -> output 32'h0000_0001 one edge later.
5. DEPTH=3: drive 32'h0000_0011, 32'h0000_0022, 32'h0000_0033 -> output shows 0, 0, then 32'h0000_0011, 32'h0000_0022, 32'h0000_0033 on the 3rd, 4th and 5th edges.
6. Hold Parallel_Data_In=32'h8000_0001 for 5 cycles -> output constant 32'h8000_0001 with no glitch; confirms MSB and LSB mapping.
